// File: rtl/led_bcm_driver.sv
// HUB75 panel driver using binary-coded modulation. Each pass shifts one bit
// plane of one row pair while the previously latched plane is being displayed,
// then latches it and starts that plane's brightness-scaled display window.
module led_bcm_driver #(
    parameter int unsigned COLS      = 64,
    parameter int unsigned ADDR_BITS = 5,
    parameter int unsigned DEPTH     = 8,
    parameter int unsigned DELAY     = 1,
    parameter int unsigned BASE_ON   = 64
) (
    input  logic                                      clk,
    input  logic                                      reset,
    input  logic                                      enable,
    input  logic [7:0]                                brightness,
    output logic [ADDR_BITS-1:0]                      req_addr,
    output logic [$clog2(COLS)-1:0]                   req_col,
    output logic [((DEPTH > 1) ? $clog2(DEPTH) : 1)-1:0] req_plane,
    input  logic [3*DEPTH-1:0]                        rgb0_in,
    input  logic [3*DEPTH-1:0]                        rgb1_in,
    output logic [2:0]                                led_rgb0,
    output logic [2:0]                                led_rgb1,
    output logic [ADDR_BITS-1:0]                      led_addr,
    output logic [1:0]                                blank_ddr,
    output logic [1:0]                                latch_ddr,
    output logic [1:0]                                sclk_ddr,
    output logic                                      frame_start
);
    localparam int unsigned CW = $clog2(COLS);
    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned NW = ($clog2(COLS) > 3) ? $clog2(COLS) : 3;
    localparam int unsigned WW = $clog2(BASE_ON) + DEPTH;
    localparam int unsigned IW = $clog2(3 * DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PREFETCH,
        S_SHIFT,
        S_WAIT,
        S_LATCH
    } state_t;

    state_t                 state_q, state_d;
    logic [NW-1:0]          cnt_q, cnt_d;
    logic [CW-1:0]          col_q, col_d;
    logic [PW-1:0]          plane_q, plane_d;
    logic [ADDR_BITS-1:0]   addr_q, addr_d;
    logic [WW-1:0]          win_q, win_d;
    logic [WW-1:0]          on_q, on_d;
    logic [2:0]             rgb0_q, rgb0_d, rgb1_q, rgb1_d;
    logic [ADDR_BITS-1:0]   led_addr_q, led_addr_d;
    logic [1:0]             blank_q, blank_d, latch_q, latch_d, sclk_q, sclk_d;
    logic                   frame_q, frame_d;

    logic [WW-1:0]          w_c;
    logic [WW-1:0]          on_c;
    logic [IW-1:0]          idx_r_c, idx_g_c, idx_b_c;

    // Window length and brightness-scaled on-time of the plane about to latch
    assign w_c  = WW'(BASE_ON) << plane_q;
    assign on_c = WW'(((WW + 8)'(w_c) * (WW + 8)'(brightness)) >> 8);

    // Bit positions of the current plane inside the packed {b,g,r} pixel
    assign idx_r_c = IW'(plane_q);
    assign idx_g_c = IW'(DEPTH) + IW'(plane_q);
    assign idx_b_c = IW'(2 * DEPTH) + IW'(plane_q);

    // State, counters and registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            col_q      <= '0;
            plane_q    <= '0;
            addr_q     <= '0;
            win_q      <= '0;
            on_q       <= '0;
            rgb0_q     <= '0;
            rgb1_q     <= '0;
            led_addr_q <= '0;
            blank_q    <= 2'b11;
            latch_q    <= 2'b00;
            sclk_q     <= 2'b00;
            frame_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            col_q      <= col_d;
            plane_q    <= plane_d;
            addr_q     <= addr_d;
            win_q      <= win_d;
            on_q       <= on_d;
            rgb0_q     <= rgb0_d;
            rgb1_q     <= rgb1_d;
            led_addr_q <= led_addr_d;
            blank_q    <= blank_d;
            latch_q    <= latch_d;
            sclk_q     <= sclk_d;
            frame_q    <= frame_d;
        end
    end

    // Pass sequencing; the display window counts down independently of the state
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        col_d      = col_q;
        plane_d    = plane_q;
        addr_d     = addr_q;
        win_d      = (win_q != '0) ? win_q - WW'(1) : win_q;
        on_d       = (on_q != '0) ? on_q - WW'(1) : on_q;
        rgb0_d     = rgb0_q;
        rgb1_d     = rgb1_q;
        led_addr_d = led_addr_q;
        blank_d    = (on_q != '0) ? 2'b00 : 2'b11;
        latch_d    = 2'b00;
        sclk_d     = 2'b00;
        frame_d    = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                blank_d = 2'b11;
                if (enable) begin
                    state_d = S_PREFETCH;
                    cnt_d   = '0;
                    col_d   = '0;
                end
            end
            S_PREFETCH: begin
                col_d = col_q + CW'(1);
                if (cnt_q == NW'(DELAY - 1)) begin
                    state_d = S_SHIFT;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + NW'(1);
                end
            end
            S_SHIFT: begin
                col_d  = col_q + CW'(1);
                sclk_d = 2'b10;
                rgb0_d = {rgb0_in[idx_b_c], rgb0_in[idx_g_c], rgb0_in[idx_r_c]};
                rgb1_d = {rgb1_in[idx_b_c], rgb1_in[idx_g_c], rgb1_in[idx_r_c]};
                if (cnt_q == NW'(COLS - 1)) begin
                    cnt_d   = '0;
                    state_d = (win_q > WW'(1)) ? S_WAIT : S_LATCH;
                end else begin
                    cnt_d = cnt_q + NW'(1);
                end
            end
            S_WAIT: begin
                if (win_q <= WW'(1)) begin
                    state_d = S_LATCH;
                    cnt_d   = '0;
                end
            end
            S_LATCH: begin
                blank_d = 2'b11;
                if (cnt_q == '0) begin
                    latch_d = 2'b11;
                    cnt_d   = NW'(1);
                end else begin
                    cnt_d   = '0;
                    col_d   = '0;
                    frame_d = (plane_q == '0) && (addr_q == '0);
                    if (plane_q == '0) begin
                        led_addr_d = addr_q;
                    end
                    if (plane_q == PW'(DEPTH - 1)) begin
                        plane_d = '0;
                        addr_d  = addr_q + ADDR_BITS'(1);
                    end else begin
                        plane_d = plane_q + PW'(1);
                    end
                    if (enable) begin
                        state_d = S_PREFETCH;
                        win_d   = w_c;
                        on_d    = on_c;
                    end else begin
                        state_d = S_IDLE;
                        win_d   = '0;
                        on_d    = '0;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign req_addr    = addr_q;
    assign req_col     = col_q;
    assign req_plane   = plane_q;
    assign led_rgb0    = rgb0_q;
    assign led_rgb1    = rgb1_q;
    assign led_addr    = led_addr_q;
    assign blank_ddr   = blank_q;
    assign latch_ddr   = latch_q;
    assign sclk_ddr    = sclk_q;
    assign frame_start = frame_q;

endmodule

// File: tb/tb_led_bcm_driver.sv
// Bench for led_bcm_driver: painter model with fixed latency, a scoreboard of
// expected shifted plane bits, and per-window blank/latch timing checks.
module tb_led_bcm_driver;
    localparam int unsigned COLS      = 4;
    localparam int unsigned ADDR_BITS = 2;
    localparam int unsigned DEPTH     = 2;
    localparam int unsigned DELAY     = 2;
    localparam int unsigned BASE_ON   = 8;
    localparam int unsigned CW        = 2;
    localparam int unsigned PW        = 1;
    localparam int unsigned NROWS     = 4;

    logic                  clk = 1'b0;
    logic                  reset;
    logic                  enable;
    logic [7:0]            brightness;
    logic [ADDR_BITS-1:0]  req_addr;
    logic [CW-1:0]         req_col;
    logic [PW-1:0]         req_plane;
    logic [3*DEPTH-1:0]    rgb0_in, rgb1_in;
    logic [2:0]            led_rgb0, led_rgb1;
    logic [ADDR_BITS-1:0]  led_addr;
    logic [1:0]            blank_ddr, latch_ddr, sclk_ddr;
    logic                  frame_start;

    int tests = 0;
    int fails = 0;
    logic [5:0] exp_q[$];
    int m_addr, m_plane;
    int l_addr, l_plane, exp_led_addr;
    logic [3*DEPTH-1:0] pipe0[DELAY];
    logic [3*DEPTH-1:0] pipe1[DELAY];

    always #5 clk = ~clk;

    led_bcm_driver #(
        .COLS(COLS), .ADDR_BITS(ADDR_BITS), .DEPTH(DEPTH), .DELAY(DELAY), .BASE_ON(BASE_ON)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable), .brightness(brightness),
        .req_addr(req_addr), .req_col(req_col), .req_plane(req_plane),
        .rgb0_in(rgb0_in), .rgb1_in(rgb1_in),
        .led_rgb0(led_rgb0), .led_rgb1(led_rgb1), .led_addr(led_addr),
        .blank_ddr(blank_ddr), .latch_ddr(latch_ddr), .sclk_ddr(sclk_ddr),
        .frame_start(frame_start)
    );

    // Pixel content: top {b=addr, g=~col, r=col}, bottom {b=~addr, g=col, r=~col}
    function automatic logic [3*DEPTH-1:0] base0(int a, int c);
        return {DEPTH'(a), ~DEPTH'(c), DEPTH'(c)};
    endfunction
    function automatic logic [3*DEPTH-1:0] base1(int a, int c);
        return {~DEPTH'(a), DEPTH'(c), ~DEPTH'(c)};
    endfunction
    // Only the requested plane is correct; other planes are inverted
    function automatic logic [3*DEPTH-1:0] pmask(int p);
        logic [DEPTH-1:0] mk;
        mk = ~(DEPTH'(1) << p);
        return {mk, mk, mk};
    endfunction
    function automatic logic [5:0] exp_led(int a, int p, int c);
        logic [3*DEPTH-1:0] t0, t1;
        t0 = base0(a, c);
        t1 = base1(a, c);
        return {t0[2*DEPTH+p], t0[DEPTH+p], t0[p], t1[2*DEPTH+p], t1[DEPTH+p], t1[p]};
    endfunction
    function automatic int win_of(int p);
        return BASE_ON << p;
    endfunction
    function automatic int on_of(int p, int b);
        return (win_of(p) * b) >> 8;
    endfunction

    // Painter with DELAY cycles of latency
    always @(posedge clk) begin
        pipe0[0] <= base0(int'(req_addr), int'(req_col)) ^ pmask(int'(req_plane));
        pipe1[0] <= base1(int'(req_addr), int'(req_col)) ^ pmask(int'(req_plane));
        for (int i = 1; i < DELAY; i++) begin
            pipe0[i] <= pipe0[i-1];
            pipe1[i] <= pipe1[i-1];
        end
    end
    assign rgb0_in = pipe0[DELAY-1];
    assign rgb1_in = pipe1[DELAY-1];

    task automatic do_reset();
        enable     = 1'b0;
        brightness = 8'd255;
        reset      = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        exp_q.delete();
        m_addr = 0; m_plane = 0;
        l_addr = 0; l_plane = 0; exp_led_addr = 0;
        @(negedge clk);
    endtask

    task automatic push_passes(int n);
        for (int k = 0; k < n; k++) begin
            for (int j = 0; j < int'(COLS); j++) exp_q.push_back(exp_led(m_addr, m_plane, j));
            m_plane++;
            if (m_plane == int'(DEPTH)) begin
                m_plane = 0;
                m_addr  = (m_addr + 1) % NROWS;
            end
        end
    endtask

    task automatic test_reset();
        int bad;
        do_reset();
        tests++; if (blank_ddr !== 2'b11) begin fails++; $display("FAIL reset_blank: got %b expected 11", blank_ddr); end
        tests++; if (latch_ddr !== 2'b00) begin fails++; $display("FAIL reset_latch: got %b expected 00", latch_ddr); end
        tests++; if (sclk_ddr !== 2'b00) begin fails++; $display("FAIL reset_sclk: got %b expected 00", sclk_ddr); end
        tests++; if ({led_rgb0, led_rgb1} !== 6'd0) begin fails++; $display("FAIL reset_rgb: got %b expected 0", {led_rgb0, led_rgb1}); end
        tests++; if ({led_addr, frame_start} !== 3'd0) begin fails++; $display("FAIL reset_addr_frame: got %b expected 0", {led_addr, frame_start}); end
        tests++; if ({req_addr, req_col, req_plane} !== 5'd0) begin fails++; $display("FAIL reset_req: got %b expected 0", {req_addr, req_col, req_plane}); end
        bad = 0;
        repeat (20) begin
            @(negedge clk);
            if (sclk_ddr !== 2'b00 || latch_ddr !== 2'b00 || blank_ddr !== 2'b11) bad++;
        end
        tests++; if (bad !== 0) begin fails++; $display("FAIL idle_hold: got %0d active cycles expected 0", bad); end
    endtask

    task automatic test_startup();
        int n, pulses, lw;
        do_reset();
        enable = 1'b1;
        @(negedge clk);
        n = 0;
        while (sclk_ddr !== 2'b10 && n < 50) begin @(negedge clk); n++; end
        tests++; if (n !== 3) begin fails++; $display("FAIL first_sclk_latency: got %0d cycles expected 3", n); end
        pulses = 0;
        while (sclk_ddr === 2'b10 && pulses < 50) begin pulses++; @(negedge clk); end
        tests++; if (pulses !== int'(COLS)) begin fails++; $display("FAIL sclk_pulses: got %0d expected %0d", pulses, COLS); end
        lw = 0;
        while (latch_ddr === 2'b11 && lw < 50) begin lw++; @(negedge clk); end
        tests++; if (lw !== 1) begin fails++; $display("FAIL latch_width: got %0d expected 1", lw); end
        tests++; if (frame_start !== 1'b1) begin fails++; $display("FAIL first_frame_start: got %b expected 1", frame_start); end
    endtask

    task automatic test_bcm(input int bright, input int npasses);
        int latches, zeros, gap, shifts, cyc, spurious, lp, la, wprev, egap;
        logic [5:0] e;
        do_reset();
        brightness = 8'(bright);
        push_passes(npasses);
        enable = 1'b1;
        latches = 0; zeros = 0; gap = 0; shifts = 0; cyc = 0; spurious = 0; lp = 0;
        while (latches < npasses && cyc < 40 * npasses + 100) begin
            @(negedge clk); cyc++; gap++;
            if (blank_ddr === 2'b00) zeros++;
            if (frame_start !== 1'b0) spurious++;
            if (sclk_ddr === 2'b10) begin
                shifts++;
                tests++;
                if (exp_q.size() == 0) begin
                    fails++; $display("FAIL shift_data_b%0d: unexpected shift, got %b expected none", bright, {led_rgb0, led_rgb1});
                end else begin
                    e = exp_q.pop_front();
                    if ({led_rgb0, led_rgb1} !== e) begin
                        fails++; $display("FAIL shift_data_b%0d: got %b expected %b", bright, {led_rgb0, led_rgb1}, e);
                    end
                end
            end
            if (latch_ddr === 2'b11) begin
                tests++; if (shifts !== int'(COLS) || blank_ddr !== 2'b11) begin
                    fails++; $display("FAIL latch_pass_b%0d: got shifts=%0d blank=%b expected %0d/11", bright, shifts, blank_ddr, COLS);
                end
                if (latches > 0) begin
                    wprev = win_of(lp);
                    egap  = ((wprev > int'(DELAY + COLS)) ? wprev : int'(DELAY + COLS)) + 2;
                    tests++; if (zeros !== on_of(lp, bright)) begin
                        fails++; $display("FAIL on_time_b%0d_p%0d: got %0d expected %0d", bright, lp, zeros, on_of(lp, bright));
                    end
                    tests++; if (gap !== egap) begin
                        fails++; $display("FAIL pass_time_b%0d_p%0d: got %0d expected %0d", bright, lp, gap, egap);
                    end
                end
                lp = l_plane; la = l_addr;
                if (lp == 0) exp_led_addr = la;
                latches++; zeros = 0; gap = 0; shifts = 0;
                l_plane++;
                if (l_plane == int'(DEPTH)) begin l_plane = 0; l_addr = (l_addr + 1) % NROWS; end
                @(negedge clk); cyc++; gap++;
                if (blank_ddr === 2'b00) zeros++;
                tests++; if (frame_start !== ((lp == 0 && la == 0) ? 1'b1 : 1'b0)) begin
                    fails++; $display("FAIL frame_start_a%0d_p%0d: got %b expected %b", la, lp, frame_start, (lp == 0 && la == 0));
                end
                tests++; if (led_addr !== ADDR_BITS'(exp_led_addr) || latch_ddr !== 2'b00) begin
                    fails++; $display("FAIL led_addr_a%0d_p%0d: got %0d latch %b expected %0d latch 00", la, lp, led_addr, latch_ddr, exp_led_addr);
                end
            end
        end
        tests++; if (latches !== npasses) begin fails++; $display("FAIL latch_count_b%0d: got %0d expected %0d", bright, latches, npasses); end
        tests++; if (exp_q.size() !== 0) begin fails++; $display("FAIL scoreboard_drain_b%0d: got %0d left expected 0", bright, exp_q.size()); end
        tests++; if (spurious !== 0) begin fails++; $display("FAIL frame_start_spurious_b%0d: got %0d expected 0", bright, spurious); end
    endtask

    task automatic test_reset_mid_shift();
        int n, bad;
        do_reset();
        enable = 1'b1;
        n = 0;
        while (led_addr !== 2'd1 && n < 500) begin @(negedge clk); n++; end
        while (sclk_ddr !== 2'b10 && n < 600) begin @(negedge clk); n++; end
        tests++; if (n >= 600) begin fails++; $display("FAIL midshift_reach: got %0d cycles expected < 600", n); end
        #2 reset = 1'b1; enable = 1'b0;
        #1;
        tests++; if ({blank_ddr, latch_ddr, sclk_ddr} !== 6'b110000) begin
            fails++; $display("FAIL async_reset_ddr: got %b expected 110000", {blank_ddr, latch_ddr, sclk_ddr});
        end
        tests++; if ({led_rgb0, led_rgb1, led_addr, frame_start} !== 9'd0) begin
            fails++; $display("FAIL async_reset_led: got %b expected 0", {led_rgb0, led_rgb1, led_addr, frame_start});
        end
        @(negedge clk);
        reset = 1'b0;
        bad = 0;
        repeat (60) begin
            @(negedge clk);
            if (latch_ddr !== 2'b00 || sclk_ddr !== 2'b00) bad++;
        end
        tests++; if (bad !== 0) begin fails++; $display("FAIL post_reset_quiet: got %0d active cycles expected 0", bad); end
    endtask

    task automatic test_enable_drop();
        int n, shifts, latches, bad;
        do_reset();
        enable = 1'b1;
        n = 0;
        while (latch_ddr !== 2'b11 && n < 200) begin @(negedge clk); n++; end
        while (sclk_ddr !== 2'b10 && n < 300) begin @(negedge clk); n++; end
        tests++; if (n >= 300) begin fails++; $display("FAIL drop_reach: got %0d cycles expected < 300", n); end
        enable = 1'b0;
        shifts = 1; latches = 0; n = 0;
        while (latches == 0 && n < 100) begin
            @(negedge clk); n++;
            if (sclk_ddr === 2'b10) shifts++;
            if (latch_ddr === 2'b11) latches++;
        end
        tests++; if (shifts !== int'(COLS)) begin fails++; $display("FAIL drop_shifts: got %0d expected %0d", shifts, COLS); end
        tests++; if (latches !== 1) begin fails++; $display("FAIL drop_latch: got %0d expected 1", latches); end
        bad = 0;
        repeat (100) begin
            @(negedge clk);
            if (sclk_ddr !== 2'b00 || latch_ddr !== 2'b00 || blank_ddr !== 2'b11) bad++;
        end
        tests++; if (bad !== 0) begin fails++; $display("FAIL drop_idle: got %0d active cycles expected 0", bad); end
    endtask

    initial begin
        reset = 1'b1; enable = 1'b0; brightness = 8'd0;
        test_reset();
        test_startup();
        test_bcm(255, 10);
        test_bcm(100, 4);
        test_bcm(0, 9);
        test_reset_mid_shift();
        test_enable_drop();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
